// File: rtl/clock_out_monitor.sv
// Measures a forwarded clock-like signal against clock: period, lock, period/stuck errors.
// Latency: registered effects of a rise appear on the 3rd clock edge after clock_in is first sampled high.
// Backpressure: none; clock_in is sampled every cycle and results are plain registered outputs.
module clock_out_monitor #(
    parameter int EXPECTED_PERIOD = 8,
    parameter int TOLERANCE       = 1,
    parameter int LOCK_COUNT      = 4,
    parameter int TIMEOUT         = 64,
    parameter int PERIOD_WIDTH    = 16,
    parameter int COUNT_WIDTH     = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clock_in,
    input  logic                    clear_errors,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    locked,
    output logic                    period_error,
    output logic                    stuck_error,
    output logic [COUNT_WIDTH-1:0]  edge_count
);

    localparam int LO_INT = (EXPECTED_PERIOD > TOLERANCE) ? (EXPECTED_PERIOD - TOLERANCE) : 0;
    localparam int HI_INT = EXPECTED_PERIOD + TOLERANCE;
    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);

    localparam logic [PERIOD_WIDTH:0]   LO_V      = LO_INT[PERIOD_WIDTH:0];
    localparam logic [PERIOD_WIDTH:0]   HI_V      = HI_INT[PERIOD_WIDTH:0];
    localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_V = TIMEOUT[PERIOD_WIDTH-1:0];
    localparam logic [RUN_W-1:0]        LOCK_V    = LOCK_COUNT[RUN_W-1:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    s1;
    logic                    s2;
    logic                    p;
    logic                    rise;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [RUN_W-1:0]        run;
    logic [RUN_W-1:0]        run_nxt;
    logic                    good;
    logic                    timeout;
    logic                    period_load;
    logic                    set_period_err;
    logic                    set_stuck;

    assign rise    = s2 & ~p;
    assign good    = ({1'b0, cnt} >= LO_V) && ({1'b0, cnt} <= HI_V);
    // A rise reloads cnt, so it always wins over a coincident timeout.
    assign timeout = ~rise && (cnt == TIMEOUT_V);

    always_ff @(posedge clock) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            p     <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
            run   <= '0;
        end else begin
            s1    <= clock_in;
            s2    <= s1;
            p     <= s2;
            state <= state_nxt;
            run   <= run_nxt;
            if (rise) begin
                cnt <= {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
            end else if (cnt != TIMEOUT_V) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        run_nxt        = run;
        period_load    = 1'b0;
        set_period_err = 1'b0;
        set_stuck      = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_nxt = MEASURE;
            end
            MEASURE: begin
                if (rise) begin
                    period_load = 1'b1;
                    if (good) begin
                        run_nxt = run + 1'b1;
                        if (run_nxt == LOCK_V) state_nxt = LOCKED;
                    end else begin
                        run_nxt = '0;
                    end
                end else if (timeout) begin
                    state_nxt = LOST;
                    set_stuck = 1'b1;
                    run_nxt   = '0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    period_load = 1'b1;
                    if (!good) begin
                        state_nxt      = MEASURE;
                        run_nxt        = '0;
                        set_period_err = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt = LOST;
                    set_stuck = 1'b1;
                    run_nxt   = '0;
                end
            end
            LOST: begin
                // The first period after recovery spans the stuck interval, so it is not evaluated.
                if (rise) state_nxt = MEASURE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            period_error <= 1'b0;
            stuck_error  <= 1'b0;
            edge_count   <= '0;
        end else begin
            period_valid <= period_load;
            locked       <= (state_nxt == LOCKED);
            if (period_load) period <= cnt;
            if (rise) edge_count <= edge_count + 1'b1;
            if (set_period_err)    period_error <= 1'b1;
            else if (clear_errors) period_error <= 1'b0;
            if (set_stuck)         stuck_error  <= 1'b1;
            else if (clear_errors) stuck_error  <= 1'b0;
        end
    end

endmodule
